// File: rtl/wb_dbg_pkg.sv
// Shared constants for the byte-stream Wishbone debug bridge:
// frame opcodes, response codes and the controller state encoding.
package wb_dbg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] RSP_ACK  = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    // Byte idx of a 32-bit word, MSB first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_dbg_master.sv
// Serial debug bridge: framed read/write commands from a byte source become
// single 32-bit Wishbone cycles, results go back out as response bytes.
//
// state   | meaning
// IDLE    | waiting for an opcode byte; unknown opcodes are dropped
// ADDR    | collecting 4 address bytes, MSB first
// DATA    | collecting 4 write-data bytes, MSB first
// BUS     | Wishbone cycle in flight, waiting for ack/err/timeout
// RESP    | streaming response bytes to the sink
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int timeout = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam int TW = $clog2(timeout) + 1;

    logic [2:0]    state;
    logic [1:0]    byte_cnt;
    logic          is_write;
    logic          resp_read;
    logic [23:0]   adr_sr;
    logic [23:0]   dat_sr;
    logic [31:0]   rd_data;
    logic [TW-1:0] tmo_cnt;
    logic          cyc;

    logic rx_fire;
    logic tx_fire;
    logic tmo_hit;

    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign tmo_hit  = (tmo_cnt == TW'(timeout - 1));
    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            byte_cnt  <= 2'd0;
            is_write  <= 1'b0;
            resp_read <= 1'b0;
            adr_sr    <= '0;
            dat_sr    <= '0;
            rd_data   <= '0;
            tmo_cnt   <= '0;
            cyc       <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            rx_ready  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
                        state    <= ST_ADDR;
                        is_write <= (rx_data == OP_WRITE);
                        byte_cnt <= 2'd0;
                    end
                end

                ST_ADDR: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Low two address bits are dropped: word accesses only.
                            wb_adr_o <= {adr_sr, rx_data[7:2], 2'b00};
                            if (is_write) begin
                                state <= ST_DATA;
                            end else begin
                                state    <= ST_BUS;
                                rx_ready <= 1'b0;
                                cyc      <= 1'b1;
                                wb_we_o  <= 1'b0;
                                wb_sel_o <= 4'hF;
                                tmo_cnt  <= '0;
                            end
                        end else begin
                            adr_sr <= {adr_sr[15:0], rx_data};
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wb_dat_o <= {dat_sr, rx_data};
                            state    <= ST_BUS;
                            rx_ready <= 1'b0;
                            cyc      <= 1'b1;
                            wb_we_o  <= 1'b1;
                            wb_sel_o <= 4'hF;
                            tmo_cnt  <= '0;
                        end else begin
                            dat_sr <= {dat_sr[15:0], rx_data};
                        end
                    end
                end

                ST_BUS: begin
                    if (wb_err_i || wb_ack_i || tmo_hit) begin
                        cyc       <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        state     <= ST_RESP;
                        byte_cnt  <= 2'd0;
                        tx_valid  <= 1'b1;
                        rd_data   <= wb_dat_i;
                        resp_read <= !wb_err_i && wb_ack_i && !is_write;
                        if (wb_err_i || !wb_ack_i)
                            tx_data <= RSP_ERR;
                        else if (is_write)
                            tx_data <= RSP_ACK;
                        else
                            tx_data <= wb_dat_i[31:24];
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_RESP: begin
                    // One idle cycle between bytes: tx_valid drops on acceptance.
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        if (!resp_read || byte_cnt == 2'd3) begin
                            state    <= ST_IDLE;
                            rx_ready <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= word_byte(rd_data, byte_cnt);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for the serial Wishbone debug bridge: transaction-level
// response model plus a per-cycle monitor on bus and byte-stream outputs.
module tb_wb_dbg_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;

    wb_dbg_master #(.timeout(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_bound(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Slave: mode 0 ack, 1 err, 2 silent, 3 err+ack; terminates in cycle sl_lat of stb.
    int          sl_mode = 0;
    int          sl_lat  = 1;
    logic [31:0] sl_rdata = 32'h0;
    int          stb_age;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) stb_age <= 0;
        else          stb_age <= wb_stb_o ? stb_age + 1 : 0;

    assign wb_ack_i = wb_stb_o && (stb_age == sl_lat - 1) && (sl_mode == 0 || sl_mode == 3);
    assign wb_err_i = wb_stb_o && (stb_age == sl_lat - 1) && (sl_mode == 1 || sl_mode == 3);
    assign wb_dat_i = sl_rdata;

    // Response model: what the host must see for one command.
    function automatic int model_len(input int mode, input int lat);
        return (mode == 2) ? TMO : lat;
    endfunction

    function automatic void model_resp(input bit is_wr, input int mode,
                                       input logic [31:0] rd, output logic [7:0] q[$]);
        q = {};
        if (mode != 0)  q.push_back(8'hEE);
        else if (is_wr) q.push_back(8'hA5);
        else for (int i = 0; i < 4; i++) q.push_back(rd[31-8*i -: 8]);
    endfunction

    // Monitor state shared with the sequencer
    logic [31:0] exp_adr, exp_dat, cap_adr, cap_dat;
    bit          exp_we;
    int          stb_cnt;
    bit          cyc_seen;
    logic [7:0]  got_q[$];

    initial begin : monitor
        logic       prev_tv, prev_tr;
        logic [7:0] prev_td;
        prev_tv = 1'b0; prev_tr = 1'b0; prev_td = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_tv = 1'b0;
            end else begin
                chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
                if (wb_stb_o) begin
                    stb_cnt++;
                    cyc_seen = 1'b1;
                    cap_adr  = wb_adr_o;
                    cap_dat  = wb_dat_o;
                    chk("bus_sel", wb_sel_o, 4'hF);
                    chk("bus_adr", wb_adr_o, exp_adr);
                    chk("bus_we", wb_we_o, exp_we);
                    if (exp_we) chk("bus_dat", wb_dat_o, exp_dat);
                end
                if (wb_stb_o || tx_valid) chk("rx_ready_closed", rx_ready, 1'b0);
                if (prev_tv && !prev_tr) begin
                    chk("tx_hold_valid", tx_valid, 1'b1);
                    chk("tx_hold_data", tx_data, prev_td);
                end
                if (tx_valid && tx_ready) got_q.push_back(tx_data);
                prev_tv = tx_valid; prev_tr = tx_ready; prev_td = tx_data;
            end
        end
    end

    // Called one time unit after a rising edge; returns in the same phase.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail_bound("rx_accept");
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic run(input string nm, input bit is_wr, input logic [31:0] adr,
                       input logic [31:0] dat, input int mode, input int lat,
                       input logic [31:0] rdata, input int bp_cycles);
        logic [7:0] exp_q[$];
        int n;
        sl_mode = mode; sl_lat = lat; sl_rdata = rdata;
        exp_adr = {adr[31:2], 2'b00}; exp_dat = dat; exp_we = is_wr;
        got_q.delete();
        stb_cnt = 0;
        model_resp(is_wr, mode, rdata, exp_q);
        if (bp_cycles > 0) tx_ready = 1'b0;
        send_byte(is_wr ? 8'h01 : 8'h02);
        for (int i = 0; i < 4; i++) send_byte(adr[31-8*i -: 8]);
        if (is_wr) for (int i = 0; i < 4; i++) send_byte(dat[31-8*i -: 8]);
        if (bp_cycles > 0) begin
            n = 0;
            while (!tx_valid && n < 200) begin @(posedge clk); #1; n++; end
            if (n >= 200) fail_bound({nm, "_tx_valid"});
            repeat (bp_cycles) @(posedge clk);
            #1;
            chk({nm, "_bp_nothing_sent"}, got_q.size(), 0);
            chk({nm, "_bp_busy"}, busy, 1'b1);
            tx_ready = 1'b1;
        end
        n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) fail_bound({nm, "_resp"});
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s_byte%0d", nm, i), got_q[i], exp_q[i]);
        chk({nm, "_stb_len"}, stb_cnt, model_len(mode, lat));
        chk({nm, "_busy_end"}, busy, 1'b0);
        chk({nm, "_rx_ready_end"}, rx_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rx_ready"}, rx_ready, 1'b0);
        chk({nm, "_tx_valid"}, tx_valid, 1'b0);
        chk({nm, "_tx_data"}, tx_data, 8'h00);
        chk({nm, "_cyc"}, wb_cyc_o, 1'b0);
        chk({nm, "_stb"}, wb_stb_o, 1'b0);
        chk({nm, "_we"}, wb_we_o, 1'b0);
        chk({nm, "_adr"}, wb_adr_o, 32'h0);
        chk({nm, "_dat"}, wb_dat_o, 32'h0);
        chk({nm, "_sel"}, wb_sel_o, 4'h0);
        chk({nm, "_busy"}, busy, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : seq
        logic [7:0] mq[$];
        reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        exp_adr = 0; exp_dat = 0; exp_we = 0; cyc_seen = 0; stb_cnt = 0;
        cap_adr = 0; cap_dat = 0;
        #3;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rx_ready_before_edge", rx_ready, 1'b0);
        @(posedge clk); #1;
        chk("rx_ready_after_edge", rx_ready, 1'b1);

        // Hand-computed pins on the model itself
        model_resp(1'b0, 0, 32'h12345678, mq);
        chk("model_rd_n", mq.size(), 4);
        chk("model_rd_b0", mq[0], 8'h12);
        chk("model_rd_b3", mq[3], 8'h78);
        chk("model_to_len", model_len(2, 1), 8);

        run("wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 3, 32'h0, 0);
        chk("wr_cap_adr", cap_adr, 32'h0000_0010);
        chk("wr_cap_dat", cap_dat, 32'hDEAD_BEEF);
        chk("wr_resp_lit", got_q.size() > 0 ? got_q[0] : 8'h00, 8'hA5);
        chk("wr_stb_lit", stb_cnt, 3);

        run("rd", 1'b0, 32'h4000_0004, 32'h0, 0, 1, 32'h1234_5678, 0);
        chk("rd_cap_adr", cap_adr, 32'h4000_0004);
        chk("rd_stb_lit", stb_cnt, 1);

        run("tmo", 1'b0, 32'h0000_0200, 32'h0, 2, 1, 32'h5555_AAAA, 0);
        chk("tmo_stb_lit", stb_cnt, 8);
        run("rd_after_tmo", 1'b0, 32'h0000_0103, 32'h0, 0, 2, 32'hCAFE_F00D, 0);
        chk("unaligned_adr", cap_adr, 32'h0000_0100);

        run("wr_err", 1'b1, 32'h0000_0300, 32'h0102_0304, 1, 2, 32'h0, 0);
        run("rd_err_ack", 1'b0, 32'h0000_0400, 32'h0, 3, 1, 32'h9999_9999, 0);
        run("rd_bp", 1'b0, 32'h0000_0500, 32'h0, 0, 1, 32'hA1B2_C3D4, 20);

        // Unknown opcode is swallowed without starting anything
        cyc_seen = 1'b0;
        send_byte(8'h7F);
        for (int i = 0; i < 5; i++) begin
            chk("bad_op_busy", busy, 1'b0);
            @(posedge clk); #1;
        end
        chk("bad_op_no_cyc", cyc_seen, 1'b0);
        chk("bad_op_rx_ready", rx_ready, 1'b1);

        // Reset in the middle of a write frame
        cyc_seen = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h11);
        chk("mid_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_cyc", cyc_seen, 1'b0);
        run("wr_after_rst", 1'b1, 32'h0000_0020, 32'h1122_3344, 0, 1, 32'h0, 0);
        chk("wr_after_rst_adr", cap_adr, 32'h0000_0020);
        chk("wr_after_rst_dat", cap_dat, 32'h1122_3344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_dbg_master.md
# wb_dbg_master

Byte-stream-driven Wishbone master (serial debug bridge) occupying one of the free master ports of `wb_conbus_top`, alongside the LM32 instruction and data masters.
- Takes framed read/write commands from a byte source, normally the receive side of a UART.
- Performs single 32-bit Wishbone cycles.
- Returns result bytes to a byte sink, normally a UART transmitter.
- Lets a host peek and poke SRAM, BRAM and peripherals independently of the CPU.

## Interface
Parameters:
- `timeout`, 1024: bus cycles to wait for `wb_ack_i`/`wb_err_i` before aborting; must be ≥ 2.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  command byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  bridge accepts byte; transfer occurs when `rx_valid && rx_ready`
- `tx_data`  out  8  response byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  sink accepts byte; transfer occurs when `tx_valid && tx_ready`
- `wb_adr_o`  out  32  byte address; bits [1:0] always 0
- `wb_dat_o`  out  32  write data
- `wb_dat_i`  in  32  read data
- `wb_sel_o`  out  4  always 4'hF during a cycle
- `wb_we_o`  out  1  write enable
- `wb_cyc_o`, `wb_stb_o`  out  1  cycle / strobe (always equal)
- `wb_ack_i`, `wb_err_i`  in  1  slave termination
- `busy`  out  1  high in any state other than IDLE

## Operation
Frame format:
- Opcode byte, then 4 address bytes, MSB first.
- Write frames (opcode 0x01) add 4 data bytes, MSB first.
- Read frames use opcode 0x02.

Any other opcode byte in IDLE is discarded silently and the bridge stays in IDLE.

States:
- IDLE → ADDR on a valid opcode.
- ADDR: accepts 4 bytes, then goes to DATA for a write or BUS for a read.
- DATA: accepts 4 bytes, then goes to BUS.
- BUS → RESP on ack, err or timeout.
- RESP → IDLE after the last response byte is accepted.

`rx_ready` is high only in IDLE, ADDR and DATA.

Responses:
- Read with ack: the 4 bytes of the captured `wb_dat_i`, MSB first.
- Write with ack: single byte 0xA5.
- Err or timeout, either opcode: single byte 0xEE.

Termination priority within one cycle: `wb_err_i` over `wb_ack_i`, and `wb_ack_i` over timeout expiry.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `wb_cyc_o`/`wb_stb_o`/`wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_sel_o`=0, `busy`=0, state IDLE. `rx_ready` rises on the first clock edge after reset release.
- Address and data shift registers load on each accepted byte.
- `wb_cyc_o`/`wb_stb_o` rise on the edge following acceptance of the final frame byte. All Wishbone outputs are registered and stable while `wb_stb_o` is high.
- Termination is sampled at each rising edge with `wb_stb_o` high. On the terminating edge:
  - `wb_cyc_o`, `wb_stb_o` and `wb_we_o` clear.
  - `wb_dat_i` is captured for a read.
  - state becomes RESP.
  - `tx_valid` rises with the first response byte.
- A zero-wait slave therefore holds `stb` for exactly 1 cycle.
- Timeout counter:
  - Clears when BUS is entered and increments each cycle `stb` is high without termination.
  - Reaching `timeout` aborts the cycle, so `stb` is high for exactly `timeout` cycles.
  - Counter width is clog2(`timeout`)+1.
- Response output: `tx_data` holds until accepted. The next byte appears the cycle after acceptance, so at most 1 byte is transferred per 2 cycles.
- After the last response byte is accepted, the bridge is in IDLE with `rx_ready`=1 on the next cycle.
- Reset asserted mid-frame or mid-cycle: all outputs return to reset values immediately, without waiting for `clk`, and the partial frame is lost.

## Structure
- Shared package/include `wb_dbg_pkg`: opcodes OP_WRITE=8'h01, OP_READ=8'h02; response codes RSP_ACK=8'hA5, RSP_ERR=8'hEE; the 5-state encoding.
- Single module, no sub-modules. Byte counter is 2 bits and is reused in ADDR, DATA and RESP.

## Test plan
- Write: rx 01 00 00 00 10 DE AD BE EF, slave acks 3 cycles after `stb` → `wb_adr_o`=0x10, `wb_dat_o`=0xDEADBEEF, `we`=1, `sel`=F, `stb` high 3 cycles; tx A5.
- Read: rx 02 40 00 00 04, zero-wait slave returns 0x12345678 → `stb` high 1 cycle, `we`=0; tx 12 34 56 78.
- Timeout: `timeout`=8, read with no ack → `stb` high exactly 8 cycles; tx EE; then a new read completes normally.
- Err, including err and ack asserted together → tx EE only, no read data bytes.
- Backpressure: `tx_ready` low 20 cycles during a read response → `tx_data` stable, no bytes lost or duplicated, `rx_ready`=0 until all 4 bytes are sent.
- Robustness: opcode 0x7F → ignored, `busy` stays 0. `reset_n` pulsed mid-write after 6 bytes → `cyc` never asserts; a subsequent full frame executes correctly.
